// File: rtl/leg_ctrl_pkg.sv
// Shared encodings for the multicycle LEGv8 control unit: FSM states, opcode
// patterns, sign-extend modes and ALU operation codes.
package leg_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    typedef enum logic [2:0] {
        CLS_ILL   = 3'd0,
        CLS_RTYPE = 3'd1,
        CLS_ITYPE = 3'd2,
        CLS_LDUR  = 3'd3,
        CLS_STUR  = 3'd4,
        CLS_B     = 3'd5,
        CLS_CBZ   = 3'd6
    } instr_class_e;

    // Full 11-bit opcodes, then the fixed prefixes of the wider-field formats.
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI_HI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI_HI = 10'b1101000100;
    localparam logic [5:0]  OP_B_HI    = 6'b000101;
    localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;

    localparam logic [1:0] SEU_ALU_IMM = 2'b00;
    localparam logic [1:0] SEU_DT_ADDR = 2'b01;
    localparam logic [1:0] SEU_BR_ADDR = 2'b10;
    localparam logic [1:0] SEU_CB_ADDR = 2'b11;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_ORR    = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_PASS_B = 4'b0111;

    localparam logic [7:0] MEM_TMO_LAST = 8'hFF;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: IR[31:21] -> instruction class, sign-extend
// mode, ALU operation and B-operand select.
module ctrl_decode
    import leg_ctrl_pkg::*;
(
    input  logic [10:0]  opcode,
    output instr_class_e cls,
    output logic [1:0]   seu,
    output logic [3:0]   alu_op,
    output logic         alu_src,
    output logic         illegal
);

    always_comb begin
        cls     = CLS_ILL;
        seu     = SEU_ALU_IMM;
        alu_op  = ALU_AND;
        alu_src = 1'b0;
        if (opcode == OP_ADD) begin
            cls    = CLS_RTYPE;
            alu_op = ALU_ADD;
        end else if (opcode == OP_SUB) begin
            cls    = CLS_RTYPE;
            alu_op = ALU_SUB;
        end else if (opcode == OP_AND) begin
            cls    = CLS_RTYPE;
            alu_op = ALU_AND;
        end else if (opcode == OP_ORR) begin
            cls    = CLS_RTYPE;
            alu_op = ALU_ORR;
        end else if (opcode[10:1] == OP_ADDI_HI) begin
            cls     = CLS_ITYPE;
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
        end else if (opcode[10:1] == OP_SUBI_HI) begin
            cls     = CLS_ITYPE;
            alu_op  = ALU_SUB;
            alu_src = 1'b1;
        end else if (opcode == OP_LDUR) begin
            cls     = CLS_LDUR;
            seu     = SEU_DT_ADDR;
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
        end else if (opcode == OP_STUR) begin
            cls     = CLS_STUR;
            seu     = SEU_DT_ADDR;
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
        end else if (opcode[10:5] == OP_B_HI) begin
            cls = CLS_B;
            seu = SEU_BR_ADDR;
        end else if (opcode[10:3] == OP_CBZ_HI) begin
            // CBZ tests the register by passing it through and watching zero.
            cls    = CLS_CBZ;
            seu    = SEU_CB_ADDR;
            alu_op = ALU_PASS_B;
        end
    end

    assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/write-back,
// counts retired instructions and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl
    import leg_ctrl_pkg::*;
#(
    // Reset value of the retired-instruction counter.
    parameter logic [31:0] INSTRET_INIT = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic        zero,
    output logic        ir_write,
    output logic [1:0]  seu,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal,
    output logic [31:0] instret
);

    logic [2:0]   state_q, state_d;
    logic [10:0]  opc_q, opc_d;
    logic [7:0]   tmo_q, tmo_d;
    logic [31:0]  instret_q, instret_d;
    logic         illegal_q, illegal_d;
    logic         retire;

    instr_class_e dec_cls;
    logic [1:0]   dec_seu;
    logic [3:0]   dec_alu_op;
    logic         dec_alu_src;
    logic         dec_illegal;

    // Only the opcode field steers control; operand fields go to the datapath IR.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[20:0];

    ctrl_decode u_decode (
        .opcode  (opc_q),
        .cls     (dec_cls),
        .seu     (dec_seu),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        seu        = SEU_ALU_IMM;
        alu_op     = ALU_AND;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    opc_d    = instr[31:21];
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                seu     = dec_seu;
                state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            end

            ST_EXEC: begin
                seu     = dec_seu;
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
                case (dec_cls)
                    CLS_RTYPE, CLS_ITYPE: state_d = ST_WB;
                    CLS_LDUR, CLS_STUR:   state_d = ST_MEM;
                    CLS_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_CBZ: begin
                        pc_write = zero;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end

            ST_MEM: begin
                seu     = dec_seu;
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
                mem_req = 1'b1;
                mem_we  = (dec_cls == CLS_STUR);
                if (mem_ack) begin
                    if (dec_cls == CLS_LDUR) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (tmo_q == MEM_TMO_LAST) begin
                    state_d = ST_TRAP;
                end
            end

            ST_WB: begin
                seu        = dec_seu;
                alu_op     = dec_alu_op;
                alu_src    = dec_alu_src;
                reg_write  = 1'b1;
                mem_to_reg = (dec_cls == CLS_LDUR);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // The timeout count is zero on the first MEM cycle and 255 on the 256th.
    assign tmo_d     = (state_q == ST_MEM) ? tmo_q + 8'd1 : 8'd0;
    assign instret_d = instret_q + {31'd0, retire};
    assign illegal_d = illegal_q | (state_d == ST_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opc_q     <= 11'd0;
            tmo_q     <= 8'd0;
            instret_q <= INSTRET_INIT;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            tmo_q     <= tmo_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second instance with a preloaded
// instret runs the same stream to exercise the counter wrap.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        imem_ack = 1'b0;
    logic        mem_ack = 1'b0;
    logic        zero = 1'b0;

    logic        imem_req, mem_req, mem_we, ir_write, alu_src, reg_write;
    logic        mem_to_reg, pc_write, pc_src, illegal;
    logic [1:0]  seu;
    logic [3:0]  alu_op;
    logic [31:0] instret;

    logic        imem_req_w, mem_req_w, mem_we_w, ir_write_w, alu_src_w, reg_write_w;
    logic        mem_to_reg_w, pc_write_w, pc_src_w, illegal_w;
    logic [1:0]  seu_w;
    logic [3:0]  alu_op_w;
    logic [31:0] instret_w;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int exp_ret = 0;
    bit mon_en = 1'b0;

    localparam logic [31:0] I_B    = 32'h14000004;
    localparam logic [31:0] I_ADDI = 32'h91000421;
    localparam logic [31:0] I_LDUR = 32'hF8408022;
    localparam logic [31:0] I_CBZ  = 32'hB4000043;
    localparam logic [31:0] I_ADD  = 32'h8B000000;
    localparam logic [31:0] I_STUR = 32'hF8000000;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .imem_req(imem_req), .imem_ack(imem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .zero(zero),
        .ir_write(ir_write), .seu(seu), .alu_op(alu_op), .alu_src(alu_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_write(pc_write),
        .pc_src(pc_src), .illegal(illegal), .instret(instret)
    );

    multicycle_ctrl #(.INSTRET_INIT(32'hFFFFFFFF)) dut_w (
        .clk(clk), .reset(reset), .instr(instr), .imem_req(imem_req_w), .imem_ack(imem_ack),
        .mem_req(mem_req_w), .mem_we(mem_we_w), .mem_ack(mem_ack), .zero(zero),
        .ir_write(ir_write_w), .seu(seu_w), .alu_op(alu_op_w), .alu_src(alu_src_w),
        .reg_write(reg_write_w), .mem_to_reg(mem_to_reg_w), .pc_write(pc_write_w),
        .pc_src(pc_src_w), .illegal(illegal_w), .instret(instret_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("fetch_reached", {31'd0, imem_req}, 32'd1);
    endtask

    // FETCH cycle with an immediate ack; returns in the DECODE cycle.
    task automatic fetch(input logic [31:0] w);
        wait_fetch();
        instr    = w;
        imem_ack = 1'b1;
        #1;
        chk("fetch_ir_pc", {29'd0, ir_write, pc_write, pc_src}, 32'h6);
        step();
        imem_ack = 1'b0;
        instr    = 32'd0;
        #1;
    endtask

    task automatic retired(input string name);
        step();
        exp_ret++;
        chk({name, "_instret"}, instret, exp_ret);
        $display("txn %s instret=%0d", name, instret);
    endtask

    always @(negedge clk) begin
        #3;
        if (mon_en && !reset) begin
            int n;
            logic bad;
            n = int'(reg_write) + int'(pc_write) + int'(ir_write) + int'(mem_req);
            bad = (n > 1) && !(n == 2 && ir_write && pc_write);
            chk("strobe_excl", {31'd0, bad}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_mem;
        repeat (3) step();
        #1;
        chk("rst_outs", {17'd0, imem_req, mem_req, mem_we, ir_write, seu, alu_op, alu_src,
                         reg_write, mem_to_reg, pc_write, pc_src, illegal}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_instret_w", instret_w, 32'hFFFFFFFF);
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        // B: 3 cycles, wraps the preloaded counter
        fetch(I_B);
        chk("b_seu", {30'd0, seu}, 32'd2);
        step();
        chk("b_exec_pc", {30'd0, pc_write, pc_src}, 32'd3);
        retired("B");
        chk("wrap_instret_w", instret_w, 32'd0);

        // ADDI: write-back in cycle 4
        fetch(I_ADDI);
        chk("addi_seu", {30'd0, seu}, 32'd0);
        step();
        chk("addi_exec", {26'd0, alu_src, alu_op, reg_write}, {26'd0, 1'b1, 4'b0010, 1'b0});
        step();
        chk("addi_wb", {30'd0, reg_write, mem_to_reg}, 32'd2);
        retired("ADDI");

        // LDUR with mem_ack on the 4th MEM cycle
        fetch(I_LDUR);
        chk("ldur_seu", {30'd0, seu}, 32'd1);
        step();
        chk("ldur_exec", {26'd0, alu_src, alu_op, mem_req}, {26'd0, 1'b1, 4'b0010, 1'b0});
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("ldur_mem", {30'd0, mem_req, mem_we}, 32'd2);
            if (k == 4) mem_ack = 1'b1;
        end
        step();
        mem_ack = 1'b0;
        #1;
        chk("ldur_wb", {29'd0, reg_write, mem_to_reg, mem_req}, 32'h6);
        retired("LDUR");

        // CBZ taken and not taken
        fetch(I_CBZ);
        chk("cbz_seu", {30'd0, seu}, 32'd3);
        zero = 1'b1;
        step();
        chk("cbz1_exec", {26'd0, pc_write, pc_src, alu_op}, {26'd0, 1'b1, 1'b1, 4'b0111});
        retired("CBZ_Z1");
        zero = 1'b0;
        fetch(I_CBZ);
        step();
        chk("cbz0_pc_write", {31'd0, pc_write}, 32'd0);
        retired("CBZ_Z0");

        // R-type ADD
        fetch(I_ADD);
        step();
        chk("add_exec", {27'd0, alu_src, alu_op}, {27'd0, 1'b0, 4'b0010});
        step();
        chk("add_wb", {31'd0, reg_write}, 32'd1);
        retired("ADD");

        // STUR, immediate ack: 4 cycles
        fetch(I_STUR);
        chk("stur_seu", {30'd0, seu}, 32'd1);
        step();
        step();
        chk("stur_mem", {30'd0, mem_req, mem_we}, 32'd3);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("stur_back_fetch", {31'd0, imem_req}, 32'd1);
        exp_ret++;
        chk("STUR_instret", instret, exp_ret);
        $display("txn STUR instret=%0d", instret);

        // STUR stalled; reset in MEM cycle 10
        fetch(I_STUR);
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("stur_stall_mem", {30'd0, mem_req, mem_we}, 32'd3);
        end
        reset = 1'b1;
        step();
        #1;
        chk("midmem_rst", {30'd0, mem_req, imem_req}, 32'd0);
        chk("midmem_instret", instret, 32'd0);
        exp_ret = 0;
        $display("txn STUR_RESET instret=%0d", instret);
        reset = 1'b0;
        step();

        // STUR timeout: 256 MEM cycles, then TRAP
        fetch(I_STUR);
        step();
        n_mem = 0;
        for (int k = 1; k <= 256; k++) begin
            step();
            n_mem += int'(mem_req);
        end
        chk("tmo_mem_cycles", n_mem, 32'd256);
        step();
        chk("tmo_trap", {30'd0, illegal, mem_req}, 32'd2);
        imem_ack = 1'b1;
        mem_ack  = 1'b1;
        instr    = I_ADDI;
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            chk("tmo_hold", {26'd0, illegal, imem_req, mem_req, reg_write, pc_write, ir_write},
                32'h20);
        end
        chk("tmo_instret", instret, 32'd0);
        $display("txn STUR_TIMEOUT illegal=%0d", illegal);
        imem_ack = 1'b0;
        mem_ack  = 1'b0;
        instr    = 32'd0;
        reset    = 1'b1;
        step();
        chk("tmo_rst_illegal", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        step();

        // Illegal opcode 0
        fetch(32'h00000000);
        chk("ill_decode_illegal", {31'd0, illegal}, 32'd0);
        step();
        chk("ill_trap", {31'd0, illegal}, 32'd1);
        imem_ack = 1'b1;
        instr    = I_ADDI;
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            chk("ill_hold", {27'd0, illegal, mem_req, reg_write, pc_write, ir_write}, 32'h10);
        end
        $display("txn ILLEGAL illegal=%0d", illegal);
        imem_ack = 1'b0;
        instr    = 32'd0;
        reset    = 1'b1;
        step();
        chk("ill_rst_illegal", {31'd0, illegal}, 32'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; all state changes on the rising clk edge.
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1  system clock
  reset  in  1  synchronous active-high reset
  instr  in  32  instruction word, valid with imem_ack
  imem_req  out  1  instruction fetch request
  imem_ack  in  1  fetch done; instr valid this cycle
  mem_req  out  1  data memory request
  mem_we  out  1  1 = store (STUR), 0 = load
  mem_ack  in  1  data access done
  zero  in  1  ALU zero flag
  ir_write  out  1  latch instr into IR
  seu  out  2  sign-extend mode: 00 ALU-imm, 01 DT addr, 10 branch addr, 11 cond-branch addr
  alu_op  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
  alu_src  out  1  1 = extended immediate as ALU B
  reg_write  out  1  register file write strobe
  mem_to_reg  out  1  1 = write-back from memory
  pc_write  out  1  PC update strobe
  pc_src  out  1  0 = PC+4, 1 = branch target
  illegal  out  1  sticky: illegal opcode or memory timeout
  instret  out  32  retired-instruction count

Function
REQ-003 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-004 IDLE SHALL go to FETCH unconditionally; all outputs 0 in IDLE.
REQ-005 FETCH SHALL assert imem_req; on imem_ack it SHALL pulse ir_write and pc_write (pc_src=0), then go to DECODE. imem_ack outside FETCH SHALL be ignored.
REQ-006 DECODE (1 cycle) SHALL classify IR[31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (R-type); ADDI 1001000100x, SUBI 1101000100x (I-type); LDUR 11111000010, STUR 11111000000; B 000101xxxxx; CBZ 10110100xxx. Anything else SHALL go to TRAP.
REQ-007 seu SHALL be driven from DECODE through the end of the instruction: I-type 00, LDUR/STUR 01, B 10, CBZ 11, R-type 00.
REQ-008 EXEC (1 cycle): R/I-type -> WB; LDUR/STUR -> MEM (alu_op ADD, alu_src 1); B -> pc_write=1, pc_src=1, retire, -> FETCH; CBZ -> alu_op pass-B, pc_write=zero, pc_src=1, retire, -> FETCH.
REQ-009 MEM SHALL hold mem_req=1 (mem_we=1 for STUR) until mem_ack; on ack, LDUR -> WB, STUR retires -> FETCH.
REQ-010 An 8-bit timeout counter SHALL clear on MEM entry; if mem_ack is not seen by the 256th MEM cycle -> TRAP.
REQ-011 WB (1 cycle) SHALL pulse reg_write (mem_to_reg=1 for LDUR only), retire, -> FETCH.
REQ-012 Minimum latency with single-cycle acks: B/CBZ 3 cycles; R/I-type, STUR 4; LDUR 5.
REQ-013 TRAP SHALL set illegal=1 and hold all other strobes 0 until reset.
REQ-014 instret SHALL increment by 1 per retired instruction and wrap from 32'hFFFFFFFF to 0.
REQ-015 reg_write, pc_write, ir_write and mem_req SHALL never be asserted in the same cycle as one another, except ir_write with pc_write in FETCH.

Reset
REQ-016 reset SHALL force state IDLE, instret 0, illegal 0, and every output 0 on the next edge; this includes reset arriving mid-MEM, where mem_req drops on that edge.

Structure
REQ-017 Package leg_ctrl_pkg SHALL hold the state encoding, opcode constants, seu mode codes and alu_op codes.
REQ-018 Opcode classification SHALL be the combinational sub-module ctrl_decode (IR[31:21] -> class, seu, alu_op, illegal).

Verification
REQ-019 ADDI 32'h91000421, acks immediate -> seu=00, alu_src=1, alu_op=0010, reg_write in cycle 4, instret +1.
REQ-020 LDUR 32'hF8408022, mem_ack delayed 3 cycles -> seu=01, mem_req held 4 cycles, mem_we=0, reg_write with mem_to_reg=1 in the following cycle.
REQ-021 CBZ 32'hB4000043, zero=1 then zero=0 -> seu=11, pc_write+pc_src=1 in EXEC only when zero=1; instret +1 in both cases.
REQ-022 instr 32'h00000000 -> TRAP, illegal=1 sticky, no reg_write/pc_write/mem_req until reset.
REQ-023 STUR with mem_ack never asserted -> TRAP after 256 MEM cycles; reset in MEM cycle 10 -> next cycle IDLE, mem_req=0, instret=0.
REQ-024 instret preloaded near 32'hFFFFFFFF, then B 32'h14000004 retired -> instret wraps to 0.
